// File: rtl/rotate_ctrl.sv
// Sequences one piece rotation: waits out the rotation datapath, then walks the
// wall-kick list against the collision checker and commits the first legal candidate.
module rotate_ctrl #(
    parameter int XW      = 5,
    parameter int ROT_LAT = 1,
    parameter int NKICK   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_dir,
    input  logic [15:0]   req_float,
    input  logic [XW-1:0] req_x,
    output logic [15:0]   rot_float,
    output logic          rot_dir,
    input  logic [15:0]   rot_result,
    output logic          chk_valid,
    output logic [15:0]   chk_float,
    output logic [XW-1:0] chk_x,
    input  logic          chk_ack,
    input  logic          chk_collide,
    input  logic          abort,
    output logic          done_valid,
    output logic          done_ok,
    output logic [15:0]   new_float,
    output logic [XW-1:0] new_x
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROT_WAIT = 3'd1,
        CHK_REQ  = 3'd2,
        CHK_WAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t        state;
    logic [15:0]   base_float;
    logic [XW-1:0] base_x;
    logic [15:0]   cand;
    logic [2:0]    kick;
    logic [1:0]    lat_cnt;

    // Kick column offsets in try order: 0, +1, -1, +2, -2 (two's complement, XW wide).
    function automatic logic [XW-1:0] kick_off(input logic [2:0] k);
        logic [XW-1:0] off;
        case (k)
            3'd0:    off = '0;
            3'd1:    off = XW'(1);
            3'd2:    off = '1;
            3'd3:    off = XW'(2);
            default: off = {{(XW-1){1'b1}}, 1'b0};
        endcase
        return off;
    endfunction

    // Handshakes: a request transfers on any edge where req_valid and req_ready are both
    // high; chk_valid is a one-cycle strobe and chk_float/chk_x stay put until chk_ack.
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base_float <= '0;
            base_x     <= '0;
            cand       <= '0;
            kick       <= '0;
            lat_cnt    <= '0;
            rot_float  <= '0;
            rot_dir    <= 1'b0;
            chk_valid  <= 1'b0;
            chk_float  <= '0;
            chk_x      <= '0;
            done_valid <= 1'b0;
            done_ok    <= 1'b0;
            new_float  <= '0;
            new_x      <= '0;
        end else begin
            chk_valid  <= 1'b0;
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base_float <= req_float;
                        base_x     <= req_x;
                        rot_float  <= req_float;
                        rot_dir    <= req_dir;
                        lat_cnt    <= '0;
                        state      <= ROT_WAIT;
                    end
                end
                ROT_WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (lat_cnt == 2'(ROT_LAT - 1)) begin
                        cand      <= rot_result;
                        kick      <= '0;
                        chk_valid <= 1'b1;
                        chk_float <= rot_result;
                        chk_x     <= base_x + kick_off(3'd0);
                        state     <= CHK_REQ;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                CHK_REQ: begin
                    state <= abort ? IDLE : CHK_WAIT;
                end
                CHK_WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (chk_ack) begin
                        if (!chk_collide) begin
                            new_float  <= cand;
                            new_x      <= chk_x;
                            done_ok    <= 1'b1;
                            done_valid <= 1'b1;
                            state      <= DONE;
                        end else if (kick == 3'(NKICK - 1)) begin
                            // Every kick collided: report the unrotated piece unchanged.
                            new_float  <= base_float;
                            new_x      <= base_x;
                            done_ok    <= 1'b0;
                            done_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            kick      <= kick + 3'd1;
                            chk_valid <= 1'b1;
                            chk_float <= cand;
                            chk_x     <= base_x + kick_off(kick + 3'd1);
                            state     <= CHK_REQ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_ctrl.sv
// Bench for rotate_ctrl: models the rotation datapath and the collision checker,
// and scores every query strobe and completion pulse against expected queues.
module tb_rotate_ctrl;

    localparam int XW    = 5;
    localparam int LAT   = 3;
    localparam int NKICK = 3;
    localparam int CW    = 16 + XW;
    localparam int DW    = 1 + 16 + XW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_dir;
    logic [15:0]   req_float;
    logic [XW-1:0] req_x;
    logic [15:0]   rot_float;
    logic          rot_dir;
    logic [15:0]   rot_result;
    logic          chk_valid;
    logic [15:0]   chk_float;
    logic [XW-1:0] chk_x;
    logic          chk_ack;
    logic          chk_collide;
    logic          abort;
    logic          done_valid;
    logic          done_ok;
    logic [15:0]   new_float;
    logic [XW-1:0] new_x;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int since    = 0;

    logic [CW-1:0] exp_chk_q[$];
    logic [DW-1:0] exp_done_q[$];

    bit            last_ok;
    logic [15:0]   last_float;
    logic [XW-1:0] last_x;

    rotate_ctrl #(.XW(XW), .ROT_LAT(LAT), .NKICK(NKICK)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
        .req_float(req_float), .req_x(req_x),
        .rot_float(rot_float), .rot_dir(rot_dir), .rot_result(rot_result),
        .chk_valid(chk_valid), .chk_float(chk_float), .chk_x(chk_x),
        .chk_ack(chk_ack), .chk_collide(chk_collide), .abort(abort),
        .done_valid(done_valid), .done_ok(done_ok),
        .new_float(new_float), .new_x(new_x)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference models ----------------
    function automatic logic [15:0] rot_model(input logic [15:0] m, input logic d);
        logic [15:0] r;
        int si, sj;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (!d) begin si = 3 - j; sj = i;     end
                else    begin si = j;     sj = 3 - i; end
                r[15 - (i*4 + j)] = m[15 - (si*4 + sj)];
            end
        end
        return r;
    endfunction

    function automatic logic [XW-1:0] offs(input int k);
        int tbl[5] = '{0, 1, -1, 2, -2};
        return XW'(tbl[k]);
    endfunction

    // Datapath stand-in: the rotated mask is only correct in the cycle before the
    // LAT-th edge after acceptance; any other capture sees the inverted mask.
    always @(posedge clk) begin
        if (rst)                           since <= 0;
        else if (req_valid && req_ready)   since <= 1;
        else if (since != 0 && since < LAT) since <= since + 1;
        else                               since <= 0;
    end
    assign rot_result = (since == LAT) ? rot_model(rot_float, rot_dir)
                                       : ~rot_model(rot_float, rot_dir);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe and every completion must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_valid) begin
                check("chk_pending", 32'(exp_chk_q.size() != 0), 32'd1);
                if (exp_chk_q.size() != 0)
                    check("chk_query", 32'({chk_float, chk_x}), 32'(exp_chk_q.pop_front()));
            end
            if (done_valid) begin
                check("done_pending", 32'(exp_done_q.size() != 0), 32'd1);
                if (exp_done_q.size() != 0)
                    check("done_result", 32'({done_ok, new_float, new_x}), 32'(exp_done_q.pop_front()));
            end
        end
    end

    task automatic check_reset();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_chk_valid", 32'(chk_valid), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_done_ok", 32'(done_ok), 32'd0);
        check("rst_rot", 32'({rot_dir, rot_float}), 32'd0);
        check("rst_chk", 32'({chk_float, chk_x}), 32'd0);
        check("rst_new", 32'({new_float, new_x}), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_chk(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (chk_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // One full rotation; coll[k] is the checker's answer for kick k.
    task automatic run_req(input logic [15:0] f, input logic [XW-1:0] x, input logic d,
                           input logic [4:0] coll, input int ack_dly, input bit ab_idle);
        logic [15:0]   rot;
        logic [XW-1:0] qx[NKICK];
        int            nq;
        bit            ok;
        bit            seen;
        int            acc_c;
        rot = rot_model(f, d);
        nq  = 0;
        ok  = 1'b0;
        for (int k = 0; k < NKICK; k++) begin
            qx[k] = x + offs(k);
            exp_chk_q.push_back({rot, qx[k]});
            nq++;
            if (!coll[k]) begin ok = 1'b1; break; end
        end
        last_ok    = ok;
        last_float = ok ? rot : f;
        last_x     = ok ? qx[nq-1] : x;
        exp_done_q.push_back({last_ok, last_float, last_x});

        check("pre_ready", 32'(req_ready), 32'd1);
        req_float = f; req_x = x; req_dir = d; req_valid = 1'b1; abort = ab_idle;
        @(negedge clk);
        req_valid = 1'b0; abort = 1'b0;
        req_float = 16'($urandom); req_x = XW'($urandom);
        acc_c = cyc;
        check("busy_ready", 32'(req_ready), 32'd0);
        check("rot_drive", 32'({rot_dir, rot_float}), 32'({d, f}));

        for (int q = 0; q < nq; q++) begin
            wait_chk(seen);
            check("chk_seen", 32'(seen), 32'd1);
            repeat (ack_dly) @(negedge clk);
            check("chk_hold", 32'({chk_valid, chk_float, chk_x}), 32'({1'b0, rot, qx[q]}));
            chk_ack = 1'b1; chk_collide = coll[q];
            @(negedge clk);
            chk_ack = 1'b0; chk_collide = 1'($urandom);
        end
        wait_done(seen);
        check("done_seen", 32'(seen), 32'd1);
        if (ack_dly == 1 && !coll[0])
            check("latency", 32'(cyc - acc_c), 32'(LAT + 2));
        @(negedge clk);
        check("done_pulse", 32'(done_valid), 32'd0);
        check("done_hold", 32'({done_ok, new_float, new_x}), 32'({last_ok, last_float, last_x}));
    endtask

    // Abort in ROT_WAIT (in_chk=0) or CHK_WAIT (in_chk=1), followed by a stray ack.
    task automatic run_abort(input logic [15:0] f, input logic [XW-1:0] x, input bit in_chk);
        bit seen;
        if (in_chk) exp_chk_q.push_back({rot_model(f, 1'b0), x});
        req_float = f; req_x = x; req_dir = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (in_chk) begin
            wait_chk(seen);
            check("abort_chk_seen", 32'(seen), 32'd1);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", 32'(req_ready), 32'd1);
        chk_ack = 1'b1; chk_collide = 1'b0;
        @(negedge clk);
        chk_ack = 1'b0;
        repeat (LAT + 6) @(negedge clk);
        check("abort_new", 32'({done_ok, new_float, new_x}), 32'({last_ok, last_float, last_x}));
        check("abort_idle", 32'(req_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        rst = 1'b1; req_valid = 1'b0; req_dir = 1'b0; req_float = '0; req_x = '0;
        chk_ack = 1'b0; chk_collide = 1'b0; abort = 1'b0;
        last_ok = 1'b0; last_float = '0; last_x = '0;
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);

        // I-piece clockwise, checker always clear
        run_req(16'h0F00, XW'(3), 1'b0, 5'b00000, 1, 1'b0);
        check("ipiece_float", 32'(new_float), 32'h2222);
        check("ipiece_x", 32'(new_x), 32'd3);

        // Kicks 0 and +1 collide, -1 clear
        run_req(16'h4E00, XW'(0), 1'b1, 5'b00011, 2, 1'b0);
        check("kick_x", 32'(new_x), 32'h1F);
        check("kick_ok", 32'(done_ok), 32'd1);

        // All kicks fail, column wraps 15 -> -16
        run_req(16'h6C00, XW'(15), 1'b0, 5'b00111, 1, 1'b0);
        check("fail_new", 32'({done_ok, new_float, new_x}), 32'({1'b0, 16'h6C00, 5'd15}));

        // Empty mask, second kick legal; abort held with the request in IDLE is ignored
        run_req(16'h0000, 5'b10000, 1'b1, 5'b00001, 3, 1'b1);

        // Aborts
        run_abort(16'h0660, XW'(4), 1'b0);
        run_abort(16'h4640, XW'(7), 1'b1);

        // Random mix
        for (int n = 0; n < 6; n++)
            run_req(16'($urandom), XW'($urandom_range(0, 31)), 1'($urandom),
                    5'($urandom_range(0, 7)), $urandom_range(1, 4), 1'b0);

        // Request held while busy, then reset mid CHK_WAIT
        exp_chk_q.push_back({rot_model(16'h4E00, 1'b0), XW'(2)});
        req_float = 16'h4E00; req_x = XW'(2); req_dir = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_float = 16'hFFFF; req_x = XW'(9);
        @(negedge clk);
        check("held_rot", 32'(rot_float), 32'h4E00);
        check("held_ready", 32'(req_ready), 32'd0);
        wait_chk(seen);
        check("held_chk_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("held_busy", 32'(req_ready), 32'd0);
        rst = 1'b1; req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;
        last_ok = 1'b0; last_float = '0; last_x = '0;
        @(negedge clk);
        run_req(16'h0F00, XW'(30), 1'b1, 5'b00010, 1, 1'b0);

        repeat (5) @(negedge clk);
        check("chk_q_left", 32'(exp_chk_q.size()), 32'd0);
        check("done_q_left", 32'(exp_done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
